// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared types for the memory bus arbiter: controller state, requester source,
// operation kind and the registered grant record.
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RADDR = 2'd1,
        RDATA = 2'd2,
        WRITE = 2'd3
    } state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    typedef struct packed {
        src_t src;
        op_t  op;
    } grant_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// One memory bus made of four independent valid/ready channels:
// read address, read data, write address, write data.
//   master : the side issuing requests (drives address/write valids, rdata_ready)
//   slave  : the side answering them (drives address/write readies, rdata/valid)
// Parameter bus_width sets the width of every address/data field.
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int bus_width = 32
);
    logic                 raddr_valid;
    logic                 raddr_ready;
    logic [bus_width-1:0] raddr;
    logic                 rdata_valid;
    logic                 rdata_ready;
    logic [bus_width-1:0] rdata;
    logic                 waddr_valid;
    logic                 waddr_ready;
    logic [bus_width-1:0] waddr;
    logic                 wdata_valid;
    logic                 wdata_ready;
    logic [bus_width-1:0] wdata;

    modport master (
        output raddr_valid, raddr, rdata_ready, waddr_valid, waddr, wdata_valid, wdata,
        input  raddr_ready, rdata_valid, rdata, waddr_ready, wdata_ready
    );

    modport slave (
        input  raddr_valid, raddr, rdata_ready, waddr_valid, waddr, wdata_valid, wdata,
        output raddr_ready, rdata_valid, rdata, waddr_ready, wdata_ready
    );
endinterface

// File: rtl/mem_bus_arbiter_pick.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pick
// Combinational requester selection.
//   d_wr/d_rd/i_wr/i_rd : eligible requests (a write needs both valids)
//   last_src            : source of the previous grant (round-robin only)
//   src/op              : selected source and operation
//   any_req             : at least one request is present
// Build option MEM_BUS_ARBITER_ROUND_ROBIN_EN: when both sources request,
// the one that did not win last time is chosen. Otherwise the data bus always
// wins. In both modes a write beats a read within the chosen source.
// -----------------------------------------------------------------------------
module mem_bus_arbiter_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic d_wr,
    input  logic d_rd,
    input  logic i_wr,
    input  logic i_rd,
    input  src_t last_src,
    output src_t src,
    output op_t  op,
    output logic any_req
);
    logic d_any;
    logic i_any;

    assign d_any   = d_wr || d_rd;
    assign i_any   = i_wr || i_rd;
    assign any_req = d_any || i_any;

`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
    always_comb begin
        if (d_any && i_any) begin
            src = (last_src == SRC_I) ? SRC_D : SRC_I;
        end else begin
            src = d_any ? SRC_D : SRC_I;
        end
    end
`else
    // Fixed priority has no memory of past grants.
    src_t unused_last_src;
    assign unused_last_src = last_src;
    assign src = d_any ? SRC_D : SRC_I;
`endif

    assign op = (src == SRC_D) ? (d_wr ? OP_WR : OP_RD)
                               : (i_wr ? OP_WR : OP_RD);
endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one memory port between the instruction bus and the data bus, one
// transaction at a time.
//   clk, rst : clock, synchronous active-high reset
//   i_bus    : instruction-bus requester (slave side)
//   d_bus    : data-bus requester (slave side)
//   m_bus    : memory port (master side)
//   busy     : high whenever a transaction is granted
// Build option MEM_BUS_ARBITER_ROUND_ROBIN_EN adds a last-source register and
// alternates between the buses under contention.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int bus_width = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  i_bus,
    mem_bus_arbiter_if.slave  d_bus,
    mem_bus_arbiter_if.master m_bus,
    output logic              busy
);
    state_t state_q, state_d;
    grant_t grant_q, grant_d;
    logic   waddr_done_q, waddr_done_d;
    logic   wdata_done_q, wdata_done_d;

    src_t   last_src;
    src_t   pick_src;
    op_t    pick_op;
    logic   pick_any;

    // Signals of the currently granted requester.
    logic [bus_width-1:0] req_raddr, req_waddr, req_wdata;
    logic                 req_rdata_ready;
    // Responses routed back to the granted requester only.
    logic rsp_raddr_ready, rsp_waddr_ready, rsp_wdata_ready, rsp_rdata_valid;
    // A write channel counts as finished if it completed earlier or completes now.
    logic waddr_fin, wdata_fin;

    mem_bus_arbiter_pick u_pick (
        .d_wr     (d_bus.waddr_valid && d_bus.wdata_valid),
        .d_rd     (d_bus.raddr_valid),
        .i_wr     (i_bus.waddr_valid && i_bus.wdata_valid),
        .i_rd     (i_bus.raddr_valid),
        .last_src (last_src),
        .src      (pick_src),
        .op       (pick_op),
        .any_req  (pick_any)
    );

`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
    src_t last_src_q, last_src_d;

    always_comb begin
        last_src_d = last_src_q;
        if (state_q == IDLE && pick_any) begin
            last_src_d = pick_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_src_q <= SRC_I;
        end else begin
            last_src_q <= last_src_d;
        end
    end

    assign last_src = last_src_q;
`else
    assign last_src = SRC_I;
`endif

    assign req_raddr       = (grant_q.src == SRC_D) ? d_bus.raddr       : i_bus.raddr;
    assign req_waddr       = (grant_q.src == SRC_D) ? d_bus.waddr       : i_bus.waddr;
    assign req_wdata       = (grant_q.src == SRC_D) ? d_bus.wdata       : i_bus.wdata;
    assign req_rdata_ready = (grant_q.src == SRC_D) ? d_bus.rdata_ready : i_bus.rdata_ready;

    // Valid is !done, so a handshake this cycle reduces to done || ready.
    assign waddr_fin = waddr_done_q || m_bus.waddr_ready;
    assign wdata_fin = wdata_done_q || m_bus.wdata_ready;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '{src: SRC_I, op: OP_RD};
            waddr_done_q <= 1'b0;
            wdata_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            waddr_done_q <= waddr_done_d;
            wdata_done_q <= wdata_done_d;
        end
    end

    // NOTE: every variable gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        waddr_done_d = waddr_done_q;
        wdata_done_d = wdata_done_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = '{src: pick_src, op: pick_op};
                    state_d = (pick_op == OP_WR) ? WRITE : RADDR;
                end
            end
            RADDR: begin
                if (m_bus.raddr_ready) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (m_bus.rdata_valid && req_rdata_ready) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (waddr_fin && wdata_fin) begin
                    state_d      = IDLE;
                    waddr_done_d = 1'b0;
                    wdata_done_d = 1'b0;
                end else begin
                    waddr_done_d = waddr_fin;
                    wdata_done_d = wdata_fin;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_bus.raddr_valid = 1'b0;
        m_bus.raddr       = '0;
        m_bus.waddr_valid = 1'b0;
        m_bus.waddr       = '0;
        m_bus.wdata_valid = 1'b0;
        m_bus.wdata       = '0;
        m_bus.rdata_ready = 1'b0;
        rsp_raddr_ready   = 1'b0;
        rsp_waddr_ready   = 1'b0;
        rsp_wdata_ready   = 1'b0;
        rsp_rdata_valid   = 1'b0;
        unique case (state_q)
            IDLE: ;
            RADDR: begin
                m_bus.raddr_valid = 1'b1;
                m_bus.raddr       = req_raddr;
                rsp_raddr_ready   = m_bus.raddr_ready;
            end
            RDATA: begin
                m_bus.rdata_ready = req_rdata_ready;
                rsp_rdata_valid   = m_bus.rdata_valid;
            end
            WRITE: begin
                m_bus.waddr_valid = !waddr_done_q;
                m_bus.waddr       = req_waddr;
                m_bus.wdata_valid = !wdata_done_q;
                m_bus.wdata       = req_wdata;
                rsp_waddr_ready   = m_bus.waddr_ready && !waddr_done_q;
                rsp_wdata_ready   = m_bus.wdata_ready && !wdata_done_q;
            end
            default: ;
        endcase
    end

    assign i_bus.raddr_ready = (grant_q.src == SRC_I) && rsp_raddr_ready;
    assign i_bus.waddr_ready = (grant_q.src == SRC_I) && rsp_waddr_ready;
    assign i_bus.wdata_ready = (grant_q.src == SRC_I) && rsp_wdata_ready;
    assign i_bus.rdata_valid = (grant_q.src == SRC_I) && rsp_rdata_valid;
    assign d_bus.raddr_ready = (grant_q.src == SRC_D) && rsp_raddr_ready;
    assign d_bus.waddr_ready = (grant_q.src == SRC_D) && rsp_waddr_ready;
    assign d_bus.wdata_ready = (grant_q.src == SRC_D) && rsp_wdata_ready;
    assign d_bus.rdata_valid = (grant_q.src == SRC_D) && rsp_rdata_valid;

    // Read data is broadcast; only the granted side sees rdata_valid.
    assign i_bus.rdata = m_bus.rdata;
    assign d_bus.rdata = m_bus.rdata;

    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed scenarios (reset, stalled read, contention, staggered and aligned
// writes, arbitration fairness) followed by a randomized phase checked against
// a transaction-level model of pending requests. Inputs are driven 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int BW = 32;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    int checks   = 0;
    int failures = 0;

    mem_bus_arbiter_if #(.bus_width(BW)) i_if ();
    mem_bus_arbiter_if #(.bus_width(BW)) d_if ();
    mem_bus_arbiter_if #(.bus_width(BW)) m_if ();

    mem_bus_arbiter #(.bus_width(BW)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_bus (i_if),
        .d_bus (d_if),
        .m_bus (m_if),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Pending requests of the random phase: 0 i_rd, 1 i_wr, 2 d_rd, 3 d_wr.
    typedef struct {
        bit          pend;
        logic [31:0] a;
        logic [31:0] dt;
    } slot_t;
    slot_t slots [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_if.raddr_valid = 0; i_if.raddr = '0; i_if.rdata_ready = 0;
        i_if.waddr_valid = 0; i_if.waddr = '0; i_if.wdata_valid = 0; i_if.wdata = '0;
        d_if.raddr_valid = 0; d_if.raddr = '0; d_if.rdata_ready = 0;
        d_if.waddr_valid = 0; d_if.waddr = '0; d_if.wdata_valid = 0; d_if.wdata = '0;
        m_if.raddr_ready = 0; m_if.waddr_ready = 0; m_if.wdata_ready = 0;
        m_if.rdata_valid = 0; m_if.rdata = '0;
    endtask

    task automatic req_read(input bit is_d, input logic [31:0] a, input bit v);
        if (is_d) begin d_if.raddr_valid = v; d_if.raddr = a; end
        else      begin i_if.raddr_valid = v; i_if.raddr = a; end
    endtask

    task automatic req_write(input bit is_d, input logic [31:0] a, input logic [31:0] dt, input bit v);
        if (is_d) begin d_if.waddr_valid = v; d_if.waddr = a; d_if.wdata_valid = v; d_if.wdata = dt; end
        else      begin i_if.waddr_valid = v; i_if.waddr = a; i_if.wdata_valid = v; i_if.wdata = dt; end
    endtask

    function automatic logic raddr_rdy(input bit is_d);
        return is_d ? d_if.raddr_ready : i_if.raddr_ready;
    endfunction
    function automatic logic waddr_rdy(input bit is_d);
        return is_d ? d_if.waddr_ready : i_if.waddr_ready;
    endfunction
    function automatic logic wdata_rdy(input bit is_d);
        return is_d ? d_if.wdata_ready : i_if.wdata_ready;
    endfunction
    function automatic logic rdata_vld(input bit is_d);
        return is_d ? d_if.rdata_valid : i_if.rdata_valid;
    endfunction
    function automatic logic [31:0] rdata_of(input bit is_d);
        return is_d ? d_if.rdata : i_if.rdata;
    endfunction
    function automatic logic rdata_rdy_in(input bit is_d);
        return is_d ? d_if.rdata_ready : i_if.rdata_ready;
    endfunction

    // Read with an always-ready memory: IDLE, RADDR, RDATA, then back to idle.
    task automatic run_read(input bit is_d, input logic [31:0] a, input logic [31:0] dt);
        req_read(is_d, a, 1'b1);
        i_if.rdata_ready = 1; d_if.rdata_ready = 1;
        m_if.raddr_ready = 1; m_if.rdata_valid = 1; m_if.rdata = dt;
        smp();
        check("rd_idle_busy", busy, 0);
        check("rd_idle_rvalid", rdata_vld(is_d), 0);
        next(); smp();
        check("rd_m_raddr_valid", m_if.raddr_valid, 1);
        check("rd_m_raddr", m_if.raddr, a);
        check("rd_grant_raddr_ready", raddr_rdy(is_d), 1);
        check("rd_other_raddr_ready", raddr_rdy(!is_d), 0);
        next();
        req_read(is_d, a, 1'b0);
        smp();
        check("rd_grant_rdata_valid", rdata_vld(is_d), 1);
        check("rd_rdata", rdata_of(is_d), dt);
        check("rd_other_rdata_valid", rdata_vld(!is_d), 0);
        check("rd_m_rdata_ready", m_if.rdata_ready, 1);
        next();
        m_if.raddr_ready = 0; m_if.rdata_valid = 0;
        smp();
        check("rd_done_busy", busy, 0);
        next();
    endtask

    // Write where both channels handshake in the first WRITE cycle.
    task automatic run_write(input bit is_d, input logic [31:0] a, input logic [31:0] dt);
        req_write(is_d, a, dt, 1'b1);
        m_if.waddr_ready = 1; m_if.wdata_ready = 1;
        smp();
        check("wr_idle_busy", busy, 0);
        check("wr_idle_waddr_valid", m_if.waddr_valid, 0);
        next(); smp();
        check("wr_busy", busy, 1);
        check("wr_m_waddr_valid", m_if.waddr_valid, 1);
        check("wr_m_wdata_valid", m_if.wdata_valid, 1);
        check("wr_m_waddr", m_if.waddr, a);
        check("wr_m_wdata", m_if.wdata, dt);
        check("wr_grant_waddr_ready", waddr_rdy(is_d), 1);
        check("wr_grant_wdata_ready", wdata_rdy(is_d), 1);
        check("wr_other_waddr_ready", waddr_rdy(!is_d), 0);
        next();
        req_write(is_d, a, dt, 1'b0);
        m_if.waddr_ready = 0; m_if.wdata_ready = 0;
        smp();
        check("wr_exit_busy", busy, 0);
        next();
    endtask

    task automatic apply_slots();
        i_if.raddr_valid = slots[0].pend; i_if.raddr = slots[0].a;
        i_if.waddr_valid = slots[1].pend; i_if.waddr = slots[1].a;
        i_if.wdata_valid = slots[1].pend; i_if.wdata = slots[1].dt;
        d_if.raddr_valid = slots[2].pend; d_if.raddr = slots[2].a;
        d_if.waddr_valid = slots[3].pend; d_if.waddr = slots[3].a;
        d_if.wdata_valid = slots[3].pend; d_if.wdata = slots[3].dt;
    endtask

    // Which pending slot the arbiter must serve next (-1 when nothing pends).
    function automatic int model_pick(input bit last_was_d);
        bit d_req, i_req, use_d;
        d_req = slots[2].pend || slots[3].pend;
        i_req = slots[0].pend || slots[1].pend;
        if (!d_req && !i_req) return -1;
`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
        use_d = (d_req && i_req) ? !last_was_d : d_req;
`else
        use_d = d_req;
`endif
        if (use_d) return slots[3].pend ? 3 : 2;
        return slots[1].pend ? 1 : 0;
    endfunction

    initial begin
        int pulses;
        int beats_a, beats_d;
        int n_grants;
        bit grant_is_d [4];
        logic [31:0] got;
        int cur, phase, completed;
        bit is_d, a_done, w_done, last_d;

        // ---------------- reset state ----------------
        idle_inputs();
        rst = 1;
        next(); next();
        smp();
        check("rst_busy", busy, 0);
        check("rst_m_raddr_valid", m_if.raddr_valid, 0);
        check("rst_m_waddr_valid", m_if.waddr_valid, 0);
        check("rst_m_wdata_valid", m_if.wdata_valid, 0);
        check("rst_m_rdata_ready", m_if.rdata_ready, 0);
        check("rst_m_raddr", m_if.raddr, 0);
        check("rst_m_waddr", m_if.waddr, 0);
        check("rst_m_wdata", m_if.wdata, 0);
        check("rst_i_raddr_ready", i_if.raddr_ready, 0);
        next();
        rst = 0;

        // ---------------- i read with two raddr stall cycles ----------------
        req_read(1'b0, 32'h0000_0040, 1'b1);
        i_if.rdata_ready = 1;
        smp();
        check("st_idle_busy", busy, 0);
        check("st_idle_raddr_valid", m_if.raddr_valid, 0);
        next(); smp();
        check("st_raddr_valid_0", m_if.raddr_valid, 1);
        check("st_raddr", m_if.raddr, 32'h40);
        check("st_i_raddr_ready_0", i_if.raddr_ready, 0);
        next(); smp();
        check("st_raddr_valid_1", m_if.raddr_valid, 1);
        next();
        m_if.raddr_ready = 1;
        smp();
        check("st_i_raddr_ready", i_if.raddr_ready, 1);
        check("st_d_raddr_ready", d_if.raddr_ready, 0);
        next();
        i_if.raddr_valid = 0; m_if.raddr_ready = 0;
        m_if.rdata_valid = 1; m_if.rdata = 32'hDEAD_BEEF;
        pulses = 0; got = '0;
        for (int c = 0; c < 4; c++) begin
            smp();
            check("st_d_rdata_valid", d_if.rdata_valid, 0);
            if (i_if.rdata_valid) begin
                pulses++;
                got = i_if.rdata;
            end
            next();
        end
        m_if.rdata_valid = 0;
        check("st_rdata_pulses", pulses, 1);
        check("st_rdata", got, 32'hDEAD_BEEF);

        // ---------------- reset while in RDATA ----------------
        req_read(1'b0, 32'h0000_0080, 1'b1);
        m_if.raddr_ready = 1;
        next();
        next();
        i_if.raddr_valid = 0; m_if.raddr_ready = 0;
        smp();
        check("mid_rdata_busy", busy, 1);
        next();
        rst = 1;
        next();
        rst = 0;
        m_if.rdata_valid = 1; m_if.rdata = 32'hBAD0_BAD0;
        smp();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_i_rdata_valid", i_if.rdata_valid, 0);
        check("mid_rst_m_rdata_ready", m_if.rdata_ready, 0);
        check("mid_rst_m_raddr_valid", m_if.raddr_valid, 0);
        check("mid_rst_m_waddr_valid", m_if.waddr_valid, 0);
        next();
        m_if.rdata_valid = 0;
        run_read(1'b0, 32'h0000_0100, 32'hCAFE_F00D);

        // ---------------- d write and i read together ----------------
        req_write(1'b1, 32'h0000_2000, 32'h1234_5678, 1'b1);
        req_read(1'b0, 32'h0000_0000, 1'b1);
        i_if.rdata_ready = 1; d_if.rdata_ready = 1;
        m_if.raddr_ready = 1; m_if.waddr_ready = 1; m_if.wdata_ready = 1;
        m_if.rdata_valid = 1; m_if.rdata = 32'h55AA_55AA;
        smp();
        check("co_idle_busy", busy, 0);
        next(); smp();
        check("co_m_waddr_valid", m_if.waddr_valid, 1);
        check("co_m_waddr", m_if.waddr, 32'h2000);
        check("co_m_wdata", m_if.wdata, 32'h1234_5678);
        check("co_m_raddr_valid", m_if.raddr_valid, 0);
        check("co_i_raddr_ready", i_if.raddr_ready, 0);
        check("co_d_wdata_ready", d_if.wdata_ready, 1);
        next();
        req_write(1'b1, 32'h0000_2000, 32'h1234_5678, 1'b0);
        smp();
        check("co_gap_busy", busy, 0);
        check("co_gap_raddr_valid", m_if.raddr_valid, 0);
        next(); smp();
        check("co_i_m_raddr_valid", m_if.raddr_valid, 1);
        check("co_i_m_raddr", m_if.raddr, 32'h0);
        check("co_i_raddr_ready", i_if.raddr_ready, 1);
        next();
        i_if.raddr_valid = 0;
        smp();
        check("co_i_rdata_valid", i_if.rdata_valid, 1);
        check("co_i_rdata", i_if.rdata, 32'h55AA_55AA);
        next();
        idle_inputs();
        smp();
        check("co_done_busy", busy, 0);
        next();

        // ---------------- wdata accepted two cycles before waddr ----------------
        req_write(1'b1, 32'h0000_3000, 32'hA5A5_A5A5, 1'b1);
        m_if.wdata_ready = 1;
        smp();
        check("sg_idle_busy", busy, 0);
        beats_a = 0; beats_d = 0;
        for (int c = 0; c < 3; c++) begin
            next();
            if (c == 2) m_if.waddr_ready = 1;
            smp();
            check("sg_busy", busy, 1);
            check("sg_m_waddr_valid", m_if.waddr_valid, 1);
            check("sg_m_wdata_valid", m_if.wdata_valid, (c == 0) ? 1 : 0);
            check("sg_d_wdata_ready", d_if.wdata_ready, (c == 0) ? 1 : 0);
            check("sg_d_waddr_ready", d_if.waddr_ready, (c == 2) ? 1 : 0);
            if (m_if.waddr_valid && m_if.waddr_ready) beats_a++;
            if (m_if.wdata_valid && m_if.wdata_ready) beats_d++;
        end
        next();
        idle_inputs();
        smp();
        check("sg_exit_busy", busy, 0);
        check("sg_waddr_beats", beats_a, 1);
        check("sg_wdata_beats", beats_d, 1);
        next();

        // ---------------- both write channels in the same cycle ----------------
        run_write(1'b0, 32'h0000_4000, 32'h0BAD_CAFE);

        // ---------------- contention with both reads held ----------------
        rst = 1;
        next();
        rst = 0;
        req_read(1'b1, 32'h0000_00D0, 1'b1);
        req_read(1'b0, 32'h0000_0010, 1'b1);
        i_if.rdata_ready = 1; d_if.rdata_ready = 1;
        m_if.raddr_ready = 1; m_if.rdata_valid = 1; m_if.rdata = 32'h1;
        n_grants = 0;
        for (int c = 0; c < 40 && n_grants < 4; c++) begin
            smp();
            if (m_if.raddr_valid && m_if.raddr_ready) begin
                grant_is_d[n_grants] = d_if.raddr_ready;
                n_grants++;
            end
            next();
        end
        check("rr_grant_count", n_grants, 4);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
            check("rr_grant_src", grant_is_d[k], (k % 2 == 0) ? 1 : 0);
`else
            check("fixed_grant_src", grant_is_d[k], 1);
`endif
        end
        idle_inputs();

        // ---------------- randomized traffic against the request model ----------------
        rst = 1;
        next();
        rst = 0;
        for (int s = 0; s < 4; s++) slots[s].pend = 0;
        cur = -1; phase = 0; completed = 0; last_d = 0;
        a_done = 0; w_done = 0; is_d = 0;
        for (int cyc = 0; cyc < 4000 && completed < 150; cyc++) begin
            if (phase == 0) begin
                for (int s = 0; s < 4; s++) begin
                    if (!slots[s].pend && $urandom_range(0, 2) == 0) begin
                        slots[s].pend = 1;
                        slots[s].a    = $urandom;
                        slots[s].dt   = $urandom;
                    end
                end
                apply_slots();
                cur = model_pick(last_d);
            end
            m_if.raddr_ready = 1'($urandom_range(0, 1));
            m_if.waddr_ready = 1'($urandom_range(0, 1));
            m_if.wdata_ready = 1'($urandom_range(0, 1));
            m_if.rdata_valid = 1'($urandom_range(0, 1));
            m_if.rdata       = $urandom;
            i_if.rdata_ready = 1'($urandom_range(0, 1));
            d_if.rdata_ready = 1'($urandom_range(0, 1));
            smp();
            is_d = (cur >= 2);
            case (phase)
                0: begin
                    check("rn_idle_busy", busy, 0);
                    check("rn_idle_raddr_valid", m_if.raddr_valid, 0);
                    check("rn_idle_waddr_valid", m_if.waddr_valid, 0);
                    check("rn_idle_wdata_valid", m_if.wdata_valid, 0);
                    if (cur >= 0) begin
                        last_d = is_d;
                        phase  = (cur % 2 == 1) ? 3 : 1;
                        a_done = 0; w_done = 0;
                    end
                end
                1: begin
                    check("rn_ra_busy", busy, 1);
                    check("rn_ra_valid", m_if.raddr_valid, 1);
                    check("rn_ra_addr", m_if.raddr, slots[cur].a);
                    check("rn_ra_grant_ready", raddr_rdy(is_d), m_if.raddr_ready);
                    check("rn_ra_other_ready", raddr_rdy(!is_d), 0);
                    check("rn_ra_waddr_valid", m_if.waddr_valid, 0);
                    if (m_if.raddr_ready) phase = 2;
                end
                2: begin
                    check("rn_rd_m_ready", m_if.rdata_ready, rdata_rdy_in(is_d));
                    check("rn_rd_grant_valid", rdata_vld(is_d), m_if.rdata_valid);
                    check("rn_rd_other_valid", rdata_vld(!is_d), 0);
                    if (m_if.rdata_valid && rdata_rdy_in(is_d)) begin
                        check("rn_rd_data", rdata_of(is_d), m_if.rdata);
                        slots[cur].pend = 0;
                        phase = 0;
                        completed++;
                    end
                end
                default: begin
                    check("rn_wr_waddr_valid", m_if.waddr_valid, !a_done);
                    check("rn_wr_wdata_valid", m_if.wdata_valid, !w_done);
                    if (!a_done) check("rn_wr_waddr", m_if.waddr, slots[cur].a);
                    if (!w_done) check("rn_wr_wdata", m_if.wdata, slots[cur].dt);
                    check("rn_wr_grant_waddr_ready", waddr_rdy(is_d), m_if.waddr_ready && !a_done);
                    check("rn_wr_grant_wdata_ready", wdata_rdy(is_d), m_if.wdata_ready && !w_done);
                    check("rn_wr_other_waddr_ready", waddr_rdy(!is_d), 0);
                    check("rn_wr_other_wdata_ready", wdata_rdy(!is_d), 0);
                    check("rn_wr_other_raddr_ready", raddr_rdy(!is_d), 0);
                    if (m_if.waddr_ready) a_done = 1;
                    if (m_if.wdata_ready) w_done = 1;
                    if (a_done && w_done) begin
                        slots[cur].pend = 0;
                        phase = 0;
                        completed++;
                    end
                end
            endcase
            next();
        end
        check("rn_progress", (completed >= 150) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
